spi_fsm: RTL and testbench
==========================

# spi_fsm

SPI slave protocol controller that consumes the conditioned SCLK edge pulses and the parallel output of the SPI shift register, and drives that register's parallel-load strobe plus the address latch, data-memory write enable and MISO tri-state enable. One transaction is framed by chip select:
- 7 address bits, then 1 R/W bit.
- Then 8 data bits, either shifted in for a write or shifted out for a read.

## Interface
Parameters:
- ADDR_WIDTH, 7, address bits in the first byte (MSB first); the byte's LSB is R/W.
- DATA_WIDTH, 8, bits per frame; equals the shift register width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- sclkPosEdge  in  1  one-clk pulse per SCLK rising edge (conditioned, synchronous to clk).
- chipSelectN  in  1  conditioned chip select, active low.
- shiftRegOut  in  DATA_WIDTH  shift register parallelDataOut.
- addrWe  out  1  address latch enable; latch captures shiftRegOut[DATA_WIDTH-1:1].
- srWe  out  1  shift register parallelLoad (loads data-memory output).
- dmWe  out  1  data-memory write enable; memory writes shiftRegOut.
- misoBufe  out  1  MISO output buffer enable.

## Operation
- Moore machine: every output is a decode of the state register only. There is no input-to-output combinational path.
- Bit counter counts sclkPosEdge pulses in the counting states. It is cleared on every state entry.
- States and transitions:
  - IDLE: chipSelectN=0 -> GET_ADDR.
  - GET_ADDR: the 8th counted sclkPosEdge -> GOT_ADDR.
  - GOT_ADDR: addrWe=1 for one cycle. If shiftRegOut[0]=1 (read) -> READ_WAIT. If 0 (write) -> WRITE_RECV.
  - READ_WAIT: one cycle for the memory read to settle -> READ_LOAD.
  - READ_LOAD: srWe=1 for one cycle -> READ_SHIFT.
  - READ_SHIFT: misoBufe=1. The 8th counted sclkPosEdge -> DONE.
  - WRITE_RECV: the 8th counted sclkPosEdge -> WRITE_STORE.
  - WRITE_STORE: dmWe=1 for one cycle -> DONE.
  - DONE: all outputs 0. chipSelectN=1 -> IDLE.
- Abort: chipSelectN=1 in any state moves to IDLE on the next edge. Abort has priority over every other transition, including a simultaneous 8th edge. No write is performed unless WRITE_STORE was actually entered.
- sclkPosEdge pulses are ignored (not counted) in IDLE, GOT_ADDR, READ_WAIT, READ_LOAD, WRITE_STORE and DONE.
- Extra SCLK edges after the frame are ignored. A new transaction needs chipSelectN to deassert and reassert.

## Timing
- Reset (nReset=0, asynchronous): state=IDLE, counter=0, addrWe=srWe=dmWe=misoBufe=0. The outputs stay 0 during reset.
- Reset mid-transaction returns to IDLE immediately. A WRITE_STORE cut by reset does not assert dmWe afterwards.
- Latencies:
  - chipSelectN falling (sampled) -> GET_ADDR on the next edge.
  - 8th address edge -> addrWe high exactly 1 clk later, for 1 clk. The shift register has shifted by then.
  - Read: addrWe -> srWe 2 clk later. misoBufe rises the cycle after srWe and stays high until DONE or abort.
  - Write: 8th data edge -> dmWe high 1 clk later, for 1 clk.
- Each enable is asserted for exactly one clk per transaction, except misoBufe.
- Required system constraint (stated, not checked): SCLK period ≥ 8 clk. This keeps all SCLK edges out of the GOT_ADDR..READ_LOAD window.

## Structure
- Package spi_fsm_pkg:
  - State enum: IDLE, GET_ADDR, GOT_ADDR, READ_WAIT, READ_LOAD, READ_SHIFT, WRITE_RECV, WRITE_STORE, DONE.
  - RW_READ=1'b1.
  - Default ADDR_WIDTH/DATA_WIDTH.
  - Counter width $clog2(DATA_WIDTH+1).
- One sub-module, spi_bit_counter:
  - Inputs: clear, count-enable (sclkPosEdge gated by state).
  - Output: done when count reaches DATA_WIDTH.
- spi_fsm holds the state register and the output decode.

## Test plan
- Reset: assert nReset=0 mid-GET_ADDR -> all four outputs 0, state IDLE. After release, nothing happens until chipSelectN falls.
- Write: CS low, shift 0x2A (addr 0x15, W), then data 0xC3 -> addrWe one clk after the 8th edge with shiftRegOut=0x2A. Then dmWe one clk after the 16th edge with shiftRegOut=0xC3. misoBufe stays 0 throughout.
- Read: CS low, shift 0x2B (addr 0x15, R) -> addrWe pulse, then srWe exactly 2 clk later, then misoBufe=1 for 8 SCLK edges. DONE is reached with misoBufe=0.
- Abort: CS high after 5 data edges of a write -> IDLE next clk, dmWe never asserted. A following full write to addr 0x01 succeeds.
- Simultaneous: chipSelectN=1 in the same clk as the 8th address sclkPosEdge -> no addrWe pulse, state IDLE.
- Overrun: 20 SCLK edges in one write frame -> exactly one dmWe pulse. Edges after the 16th are ignored until CS toggles.

Source files
------------

// File: rtl/spi_fsm_pkg.sv
// Shared types and defaults for the SPI slave protocol controller.
package spi_fsm_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 7;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned CNT_WIDTH_DEF  = $clog2(DATA_WIDTH_DEF + 1);

    // Value of the LSB of the first byte that requests a read.
    localparam logic RW_READ = 1'b1;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        GET_ADDR    = 4'd1,
        GOT_ADDR    = 4'd2,
        READ_WAIT   = 4'd3,
        READ_LOAD   = 4'd4,
        READ_SHIFT  = 4'd5,
        WRITE_RECV  = 4'd6,
        WRITE_STORE = 4'd7,
        DONE        = 4'd8
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Counts qualified SCLK rising-edge pulses; flags the pulse that completes a frame.
module spi_bit_counter
    import spi_fsm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_en_i,
    output logic done_c_o
);

    localparam int unsigned CNT_WIDTH = cnt_width(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Clear wins over counting; the count saturates at a full frame.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && (cnt_q != CNT_FULL)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High during the pulse that brings the count to DATA_WIDTH.
    assign done_c_o = count_en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/spi_fsm.sv
// SPI slave transaction sequencer: address byte with R/W flag, then one data byte.
module spi_fsm
    import spi_fsm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  sclkPosEdge,
    input  logic                  chipSelectN,
    input  logic [DATA_WIDTH-1:0] shiftRegOut,
    output logic                  addrWe,
    output logic                  srWe,
    output logic                  dmWe,
    output logic                  misoBufe
);

    // R/W flag sits just below the address field in the first byte.
    localparam int unsigned RW_BIT = DATA_WIDTH - ADDR_WIDTH - 1;

    state_e state_q;
    state_e state_d;

    logic addr_we_q, addr_we_d;
    logic sr_we_q,   sr_we_d;
    logic dm_we_q,   dm_we_d;
    logic miso_q,    miso_d;

    logic count_en;
    logic cnt_clear;
    logic frame_done_c;

    // The address field is captured by the external latch, not here.
    logic [ADDR_WIDTH-1:0] unused_addr;
    assign unused_addr = shiftRegOut[DATA_WIDTH-1 -: ADDR_WIDTH];

    assign count_en  = sclkPosEdge &&
                       (state_q inside {GET_ADDR, READ_SHIFT, WRITE_RECV});
    assign cnt_clear = (state_d != state_q);

    spi_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bit_counter (
        .clk        (clk),
        .rst_n      (nReset),
        .clear_i    (cnt_clear),
        .count_en_i (count_en),
        .done_c_o   (frame_done_c)
    );

    // Next state; chip-select release preempts every other transition.
    always_comb begin
        state_d = state_q;
        if (chipSelectN) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:        state_d = GET_ADDR;
                GET_ADDR:    if (frame_done_c) state_d = GOT_ADDR;
                GOT_ADDR:    state_d = (shiftRegOut[RW_BIT] == RW_READ) ? READ_WAIT : WRITE_RECV;
                READ_WAIT:   state_d = READ_LOAD;
                READ_LOAD:   state_d = READ_SHIFT;
                READ_SHIFT:  if (frame_done_c) state_d = DONE;
                WRITE_RECV:  if (frame_done_c) state_d = WRITE_STORE;
                WRITE_STORE: state_d = DONE;
                DONE:        state_d = DONE;
                default:     state_d = IDLE;
            endcase
        end
    end

    // Enables are registered from the next state so each one tracks state_q exactly.
    always_comb begin
        addr_we_d = 1'b0;
        sr_we_d   = 1'b0;
        dm_we_d   = 1'b0;
        miso_d    = 1'b0;
        case (state_d)
            GOT_ADDR:    addr_we_d = 1'b1;
            READ_LOAD:   sr_we_d   = 1'b1;
            READ_SHIFT:  miso_d    = 1'b1;
            WRITE_STORE: dm_we_d   = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            addr_we_q <= 1'b0;
            sr_we_q   <= 1'b0;
            dm_we_q   <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_we_q <= addr_we_d;
            sr_we_q   <= sr_we_d;
            dm_we_q   <= dm_we_d;
            miso_q    <= miso_d;
        end
    end

    assign addrWe   = addr_we_q;
    assign srWe     = sr_we_q;
    assign dmWe     = dm_we_q;
    assign misoBufe = miso_q;

endmodule

// File: tb/tb_spi_fsm.sv
// Self-checking bench for spi_fsm: transaction-level model compared every cycle, plus directed literal checks.
module tb_spi_fsm;

    localparam int unsigned DW = 8;

    logic          clk         = 1'b0;
    logic          nReset      = 1'b0;
    logic          sclkPosEdge = 1'b0;
    logic          chipSelectN = 1'b1;
    logic [DW-1:0] shiftRegOut = '0;
    logic          addrWe;
    logic          srWe;
    logic          dmWe;
    logic          misoBufe;

    always #5 clk = ~clk;

    spi_fsm #(
        .ADDR_WIDTH (7),
        .DATA_WIDTH (8)
    ) dut (
        .clk         (clk),
        .nReset      (nReset),
        .sclkPosEdge (sclkPosEdge),
        .chipSelectN (chipSelectN),
        .shiftRegOut (shiftRegOut),
        .addrWe      (addrWe),
        .srWe        (srWe),
        .dmWe        (dmWe),
        .misoBufe    (misoBufe)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a frame is tracked as edges seen and clock cycles elapsed since the address byte completed.
    bit m_active = 0;
    bit m_rw     = 0;
    int m_naddr  = 0;
    int m_k      = -1;
    int m_ndata  = 0;
    int m_post   = -1;
    bit e_addr = 0, e_sr = 0, e_dm = 0, e_miso = 0;

    task automatic model_clear();
        m_active = 0; m_rw = 0; m_naddr = 0; m_k = -1; m_ndata = 0; m_post = -1;
    endtask

    always @(posedge clk or negedge nReset) begin
        if (!nReset || chipSelectN) begin
            model_clear();
        end else if (!m_active) begin
            model_clear();
            m_active = 1;
        end else if (m_k < 0) begin
            if (sclkPosEdge) begin
                m_naddr++;
                if (m_naddr == 8) m_k = 0;
            end
        end else begin
            if (m_k == 0) m_rw = shiftRegOut[0];
            // Read data edges count from 3 cycles after the address, write edges from 1.
            if (sclkPosEdge && m_ndata < 8 && (m_rw ? (m_k >= 3) : (m_k >= 1))) begin
                m_ndata++;
                if (m_ndata == 8) m_post = 0;
            end else if (m_post >= 0) begin
                m_post++;
            end
            if (m_k < 1000) m_k++;
        end
        e_addr = (m_k == 0);
        e_sr   = m_rw && (m_k == 2);
        e_miso = m_rw && (m_k >= 3) && (m_ndata < 8);
        e_dm   = !m_rw && (m_post == 0);
    end

    // Per-transaction observations for the directed literal checks.
    int  n_addr = 0, n_sr = 0, n_dm = 0, n_miso = 0;
    int  addr_cyc = 0, sr_cyc = 0, miso_first = 0;
    logic [DW-1:0] addr_val = '0, dm_val = '0;

    always @(negedge clk) begin
        cyc++;
        if (cyc > 2) begin
            chk("addrWe",   32'(addrWe),   32'(e_addr));
            chk("srWe",     32'(srWe),     32'(e_sr));
            chk("dmWe",     32'(dmWe),     32'(e_dm));
            chk("misoBufe", 32'(misoBufe), 32'(e_miso));
        end
        if (addrWe === 1'b1) begin n_addr++; addr_cyc = cyc; addr_val = shiftRegOut; end
        if (srWe === 1'b1)   begin n_sr++;   sr_cyc = cyc; end
        if (dmWe === 1'b1)   begin n_dm++;   dm_val = shiftRegOut; end
        if (misoBufe === 1'b1) begin
            if (n_miso == 0) miso_first = cyc;
            n_miso++;
        end
    end

    task automatic clear_counts();
        n_addr = 0; n_sr = 0; n_dm = 0; n_miso = 0;
        addr_cyc = 0; sr_cyc = 0; miso_first = 0;
        addr_val = '0; dm_val = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // One SCLK period of 8 clk; the shift register moves one clk after the edge pulse.
    task automatic sclk_bit(input logic b);
        sclkPosEdge = 1'b1;
        tick(1);
        sclkPosEdge = 1'b0;
        shiftRegOut = {shiftRegOut[DW-2:0], b};
        tick(7);
    endtask

    task automatic send_bits(input logic [7:0] v, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) sclk_bit(v[i]);
    endtask

    task automatic cs_low();
        chipSelectN = 1'b0;
        tick(2);
    endtask

    task automatic cs_high();
        chipSelectN = 1'b1;
        tick(3);
    endtask

    initial begin
        tick(3);
        nReset = 1'b1;
        tick(2);

        // Reset mid-GET_ADDR, then idle edges with CS high do nothing.
        clear_counts();
        cs_low();
        send_bits(8'h2A, 3);
        nReset = 1'b0;
        chipSelectN = 1'b1;
        #1;
        chk("rst_addrWe",   32'(addrWe),   32'd0);
        chk("rst_misoBufe", 32'(misoBufe), 32'd0);
        tick(3);
        nReset = 1'b1;
        tick(1);
        send_bits(8'hFF, 4);
        chk("idle_addr_pulses", 32'(n_addr), 32'd0);
        chk("idle_dm_pulses",   32'(n_dm),   32'd0);

        // Write 0x2A (addr 0x15, W), data 0xC3.
        clear_counts();
        cs_low();
        send_bits(8'h2A, 8);
        send_bits(8'hC3, 8);
        tick(4);
        cs_high();
        chk("wr_addr_pulses", 32'(n_addr),   32'd1);
        chk("wr_addr_value",  32'(addr_val), 32'h2A);
        chk("wr_dm_pulses",   32'(n_dm),     32'd1);
        chk("wr_dm_value",    32'(dm_val),   32'hC3);
        chk("wr_sr_pulses",   32'(n_sr),     32'd0);
        chk("wr_miso_cycles", 32'(n_miso),   32'd0);

        // Read 0x2B (addr 0x15, R).
        clear_counts();
        cs_low();
        send_bits(8'h2B, 8);
        send_bits(8'h00, 8);
        tick(3);
        chk("rd_done_miso",    32'(misoBufe),              32'd0);
        cs_high();
        chk("rd_addr_pulses",  32'(n_addr),                32'd1);
        chk("rd_sr_pulses",    32'(n_sr),                  32'd1);
        chk("rd_addr_to_sr",   32'(sr_cyc - addr_cyc),     32'd2);
        chk("rd_sr_to_miso",   32'(miso_first - sr_cyc),   32'd1);
        chk("rd_miso_cycles",  32'(n_miso),                32'd61);
        chk("rd_dm_pulses",    32'(n_dm),                  32'd0);

        // Abort a write after 5 data edges; a following write to 0x01 succeeds.
        clear_counts();
        cs_low();
        send_bits(8'h2A, 8);
        send_bits(8'hFF, 5);
        cs_high();
        chk("abort_dm_pulses", 32'(n_dm), 32'd0);
        clear_counts();
        cs_low();
        send_bits(8'h02, 8);
        send_bits(8'h5A, 8);
        tick(2);
        cs_high();
        chk("post_abort_addr_value", 32'(addr_val), 32'h02);
        chk("post_abort_dm_pulses",  32'(n_dm),     32'd1);
        chk("post_abort_dm_value",   32'(dm_val),   32'h5A);

        // CS rises in the same clk as the 8th address edge.
        clear_counts();
        cs_low();
        send_bits(8'h2A, 7);
        sclkPosEdge = 1'b1;
        chipSelectN = 1'b1;
        tick(1);
        sclkPosEdge = 1'b0;
        tick(4);
        chk("simul_addr_pulses", 32'(n_addr), 32'd0);

        // 20 edges in one write frame.
        clear_counts();
        cs_low();
        send_bits(8'h04, 8);
        send_bits(8'h96, 8);
        send_bits(8'hF0, 4);
        cs_high();
        chk("overrun_addr_pulses", 32'(n_addr), 32'd1);
        chk("overrun_dm_pulses",   32'(n_dm),   32'd1);
        chk("overrun_dm_value",    32'(dm_val), 32'h96);

        // Reset in the middle of a read data phase drops misoBufe at once.
        clear_counts();
        cs_low();
        send_bits(8'h2B, 8);
        send_bits(8'h00, 2);
        chk("rd_mid_miso", 32'(misoBufe), 32'd1);
        nReset = 1'b0;
        #1;
        chk("rst_mid_read_miso", 32'(misoBufe), 32'd0);
        tick(2);
        chipSelectN = 1'b1;
        nReset = 1'b1;
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
